// File: rtl/hit_keypad_scanner_if.sv
// Keypad scanner signal bundle: game state and raw rows in, column drive and
// hit pulse out. The scanner connects through the slave modport.
`timescale 1ns/1ps
interface hit_keypad_scanner_if;
    logic [3:0]  state;      // one-hot game state, 0010 = inGame
    logic [3:0]  row_in;     // raw keypad rows, active-low, asynchronous
    logic [3:0]  col_out;    // column drive, active-low one-hot
    logic [15:0] hit_Index;  // one-cycle one-hot hit, bit = row*4+col
    logic        key_valid;  // high with any nonzero hit_Index

    modport master (output state, row_in, input col_out, hit_Index, key_valid);
    modport slave  (input state, row_in, output col_out, hit_Index, key_valid);
endinterface

// File: rtl/hit_keypad_scanner.sv
// 4x4 keypad scanner for the whack-a-mole game. Columns are driven low one at
// a time; a row going low freezes the column, is debounced for press and
// release, and an accepted press emits a single one-hot hit pulse in inGame.
// Optional macro HIT_LOCKOUT_EN adds a hit suppression window after each
// emitted hit.
`timescale 1ns/1ps
module hit_keypad_scanner #(
    parameter int SCAN_DIV       = 49,
    parameter int DEBOUNCE_CNT   = 499,
    parameter int LOCKOUT_CYCLES = 4999
) (
    input logic                 clk,
    input logic                 rst,
    hit_keypad_scanner_if.slave kif
);
    localparam int DW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [3:0]    IN_GAME = 4'b0010;
    localparam logic [3:0]    IDLE    = 4'b1111;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} fsm_t;

    fsm_t          fsm_q;
    logic [3:0]    sync_q;
    logic [3:0]    rows_s;
    logic [3:0]    col_q;     // active-low one-hot, drives col_out directly
    logic [3:0]    pat_q;     // row pattern captured when leaving SCAN
    logic [DW-1:0] div_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   hit_q;
    logic          kv_q;
    logic          accept;
    logic          emit;
    logic          lock_free;

    // Index of the lowest zero bit; used for both row (lowest row wins) and
    // the active column.
    function automatic logic [1:0] low_zero(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Two-flop synchronizer for the asynchronous rows, idle high in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= IDLE;
            rows_s <= IDLE;
        end else begin
            sync_q <= kif.row_in;
            rows_s <= sync_q;
        end
    end

    // A press is accepted on the last stable debounce cycle; the pulse itself
    // is gated by the game state sampled in that same cycle.
    assign accept = (fsm_q == DEBOUNCE) && (rows_s == pat_q) && (cnt_q == CNT_MAX);
    assign emit   = accept && (kif.state == IN_GAME) && lock_free;

`ifdef HIT_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT_CYCLES);
    logic [LW-1:0] lock_q;

    assign lock_free = (lock_q == '0);

    // Lockout window: reload on every emitted hit, count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock_q <= '0;
        else if (emit)
            lock_q <= LOCK_MAX;
        else if (lock_q != '0)
            lock_q <= lock_q - 1'b1;
    end
`else
    assign lock_free = 1'b1;
`endif

    // Scan/debounce FSM with registered column drive and hit pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= SCAN;
            col_q <= 4'b1110;
            div_q <= '0;
            cnt_q <= '0;
            pat_q <= IDLE;
            hit_q <= '0;
            kv_q  <= 1'b0;
        end else begin
            hit_q <= '0;
            kv_q  <= 1'b0;
            case (fsm_q)
                SCAN: begin
                    if (rows_s != IDLE) begin
                        fsm_q <= DEBOUNCE;
                        pat_q <= rows_s;
                        cnt_q <= '0;
                        div_q <= '0;
                    end else if (div_q == DIV_MAX) begin
                        div_q <= '0;
                        col_q <= {col_q[2:0], col_q[3]};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != pat_q) begin
                        // bounce: resume scanning from the held column
                        fsm_q <= SCAN;
                        cnt_q <= '0;
                    end else if (accept) begin
                        fsm_q <= PRESSED;
                        cnt_q <= '0;
                        if (emit) begin
                            hit_q <= 16'd1 << {low_zero(pat_q), low_zero(col_q)};
                            kv_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (rows_s == IDLE) begin
                        fsm_q <= RELEASE;
                        cnt_q <= '0;
                    end
                end
                RELEASE: begin
                    if (rows_s != IDLE) begin
                        fsm_q <= PRESSED;
                    end else if (cnt_q == CNT_MAX) begin
                        fsm_q <= SCAN;
                        cnt_q <= '0;
                        div_q <= '0;
                        col_q <= {col_q[2:0], col_q[3]};
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: fsm_q <= SCAN;
            endcase
        end
    end

    assign kif.col_out   = col_q;
    assign kif.hit_Index = hit_q;
    assign kif.key_valid = kv_q;
endmodule

// File: tb/tb_hit_keypad_scanner.sv
// Self-checking bench for hit_keypad_scanner. A keypad model turns the set of
// held keys plus the driven column into row levels; expectations come from the
// game rules (which key, which state, lockout window), not from FSM timing.
`timescale 1ns/1ps
module tb_hit_keypad_scanner;
    localparam int SCAN_DIV       = 3;
    localparam int DEBOUNCE_CNT   = 7;
    localparam int LOCKOUT_CYCLES = 40;
    localparam logic [3:0] BEFORE = 4'b0001;
    localparam logic [3:0] INGAME = 4'b0010;
`ifdef HIT_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    hit_keypad_scanner_if kif();

    hit_keypad_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .kif(kif.slave)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_pulse = 0;
    int          last_pulse_cyc = -1000;
    logic [15:0] last_hit = '0;
    logic [15:0] keys = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] p;
        p = 4'b1111;
        p[c] = 1'b0;
        return p;
    endfunction

    function automatic logic [15:0] onehot16(input int n);
        logic [15:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // Row r reads low when any held key in row r sits on the driven column.
    function automatic logic [3:0] keypad_rows(input logic [15:0] k, input logic [3:0] cols);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                if (k[rr*4+c] && !cols[c]) r[rr] = 1'b0;
        return r;
    endfunction

    task automatic set_keys(input logic [15:0] k);
        keys = k;
        kif.row_in = keypad_rows(keys, kif.col_out);
    endtask

    // One clock: sample after the edge, check invariants, update keypad rows.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("key_valid", 32'(kif.key_valid), 32'(|kif.hit_Index));
        chk("hit_onehot0", 32'($onehot0(kif.hit_Index)), 1);
        chk("col_onehot", 32'($onehot(~kif.col_out)), 1);
        if (kif.hit_Index != '0) begin
            n_pulse++;
            last_hit = kif.hit_Index;
            last_pulse_cyc = cyc;
        end
        kif.row_in = keypad_rows(keys, kif.col_out);
    endtask

    // Wait for column c to newly become active.
    task automatic wait_col(input int c);
        int i;
        i = 0;
        while (kif.col_out == col_pat(c) && i < 20) begin tick(); i++; end
        i = 0;
        while (kif.col_out != col_pat(c) && i < 20) begin tick(); i++; end
        chk("wait_col", 32'(kif.col_out), 32'(col_pat(c)));
    endtask

    task automatic wait_pulse(input int maxc, output bit got, output int lat);
        int p0;
        p0 = n_pulse;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (n_pulse != p0) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_all();
        set_keys('0);
        repeat (2*DEBOUNCE_CNT + 8) tick();
    endtask

    // Full press on column c: expected pulse (or none), latency window, no
    // repeat while held, no pulse on release.
    task automatic press(input string tag, input logic [15:0] k, input int c,
                         input bit expect_hit, input logic [15:0] exp_hit, input int hold);
        bit got;
        int lat;
        int p0;
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(c);
        set_keys(k);
        wait_pulse(DEBOUNCE_CNT + 8, got, lat);
        chk({tag, "_pulse"}, 32'(got), 32'(expect_hit));
        if (got) begin
            chk({tag, "_idx"}, 32'(last_hit), 32'(exp_hit));
            chk({tag, "_lat"}, 32'(lat >= DEBOUNCE_CNT + 2 && lat <= DEBOUNCE_CNT + 4), 1);
        end
        p0 = n_pulse;
        repeat (hold) tick();
        chk({tag, "_norepeat"}, n_pulse - p0, 0);
        p0 = n_pulse;
        release_all();
        chk({tag, "_release"}, n_pulse - p0, 0);
    endtask

    initial begin
        bit          got;
        int          lat;
        int          p0;
        int          t1;
        int          r;
        int          c;
        logic [3:0]  rm;
        logic [15:0] k;

        kif.state  = INGAME;
        kif.row_in = 4'hF;
        keys       = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", 32'(kif.col_out), 32'(4'b1110));
        chk("rst_hit", 32'(kif.hit_Index), 0);
        chk("rst_kv", 32'(kif.key_valid), 0);
        rst = 1'b0;

        // idle scan: each column held SCAN_DIV+1 cycles
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("scan_col", 32'(kif.col_out), 32'(col_pat((i / (SCAN_DIV+1)) % 4)));
            chk("idle_hit", 32'(kif.hit_Index), 0);
        end

        // row 2 on column 1 -> bit 9
        press("r2c1", onehot16(9), 1, 1'b1, 16'h0200, 20);

        // bounce of 4 cycles: no pulse, column frozen then resumed
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(2);
        p0 = n_pulse;
        set_keys(onehot16(0*4+2));
        repeat (4) tick();
        set_keys('0);
        repeat (4) tick();
        chk("bounce_col_held", 32'(kif.col_out), 32'(col_pat(2)));
        repeat (30) tick();
        chk("bounce_nopulse", n_pulse - p0, 0);

        // row 3 col 3 outside the game, then in game
        kif.state = BEFORE;
        press("r3c3_before", onehot16(15), 3, 1'b0, 16'h0000, 10);
        kif.state = INGAME;
        press("r3c3_ingame", onehot16(15), 3, 1'b1, 16'h8000, 10);

        // rows 1 and 3 on column 0 -> row 1 wins; long hold; release glitch
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(0);
        k = onehot16(4) | onehot16(12);
        set_keys(k);
        wait_pulse(DEBOUNCE_CNT + 8, got, lat);
        chk("multi_pulse", 32'(got), 1);
        chk("multi_idx", 32'(last_hit), 32'h0010);
        p0 = n_pulse;
        repeat (100) tick();
        chk("multi_hold", n_pulse - p0, 0);
        set_keys('0);
        repeat (3) tick();
        set_keys(k);
        repeat (20) tick();
        chk("multi_glitch", n_pulse - p0, 0);
        release_all();

        // state leaves inGame mid-debounce: no pulse
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(1);
        set_keys(onehot16(5));
        repeat (5) tick();
        kif.state = BEFORE;
        wait_pulse(15, got, lat);
        chk("leave_game_nopulse", 32'(got), 0);
        release_all();

        // state enters inGame mid-debounce: pulse
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(3);
        set_keys(onehot16(7));
        repeat (5) tick();
        kif.state = INGAME;
        wait_pulse(15, got, lat);
        chk("enter_game_pulse", 32'(got), 1);
        chk("enter_game_idx", 32'(last_hit), 32'h0080);
        release_all();

        // lockout: second press ~20 cycles after first
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(0);
        set_keys(onehot16(2*4+0));
        wait_pulse(DEBOUNCE_CNT + 8, got, lat);
        chk("lock1_pulse", 32'(got), 1);
        t1 = last_pulse_cyc;
        set_keys(onehot16(1*4+1));
        wait_pulse(2*DEBOUNCE_CNT + 16, got, lat);
        chk("lock_near_pulse", 32'(got), 32'(!LOCK_EN));
        if (got) begin
            chk("lock_near_idx", 32'(last_hit), 32'h0020);
            chk("lock_near_gap", 32'(last_pulse_cyc - t1 <= LOCKOUT_CYCLES), 1);
        end
        release_all();

        // lockout: presses further apart than the window both pulse
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(0);
        set_keys(onehot16(2*4+0));
        wait_pulse(DEBOUNCE_CNT + 8, got, lat);
        chk("far1_pulse", 32'(got), 1);
        t1 = last_pulse_cyc;
        release_all();
        repeat (LOCKOUT_CYCLES) tick();
        set_keys(onehot16(3*4+2));
        wait_pulse(4*(SCAN_DIV+1) + DEBOUNCE_CNT + 8, got, lat);
        chk("far2_pulse", 32'(got), 1);
        chk("far2_idx", 32'(last_hit), 32'h4000);
        chk("far2_gap", 32'(last_pulse_cyc - t1 > LOCKOUT_CYCLES), 1);
        release_all();

        // random keys, row masks and game states
        for (int it = 0; it < 6; it++) begin
            c  = int'($urandom_range(0, 3));
            rm = 4'($urandom_range(1, 15));
            k  = '0;
            r  = -1;
            for (int rr = 3; rr >= 0; rr--)
                if (rm[rr]) begin
                    k = k | onehot16(rr*4 + c);
                    r = rr;
                end
            kif.state = ($urandom_range(0, 1) == 1) ? INGAME : BEFORE;
            press("rand", k, c, kif.state == INGAME, onehot16(r*4 + c),
                  int'($urandom_range(5, 30)));
        end
        kif.state = INGAME;

        // asynchronous reset while a pulse is visible drops it at once
        repeat (LOCKOUT_CYCLES) tick();
        wait_col(2);
        set_keys(onehot16(1*4+2));
        wait_pulse(DEBOUNCE_CNT + 8, got, lat);
        chk("arst_pre_pulse", 32'(got), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hit", 32'(kif.hit_Index), 0);
        chk("arst_kv", 32'(kif.key_valid), 0);
        chk("arst_col", 32'(kif.col_out), 32'(4'b1110));
        set_keys('0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("arst_scan_col", 32'(kif.col_out), 32'(col_pat((i / (SCAN_DIV+1)) % 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
